// File: rtl/layer_controller_if.sv
// Command and datapath-control bundle between the layer sequencer and its
// command issuer / PE array.
interface layer_controller_if #(
    parameter int CNT_W = 4,
    parameter int WIN_W = 10
);
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] taps;
    logic [WIN_W-1:0] windows;
    logic             wr_ready;
    logic             ifm_read;
    logic             wgt_read;
    logic             bias_read;
    logic             acc_clr;
    logic             comp_en;
    logic             wr_en;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, mode, taps, windows, wr_ready,
        input  ifm_read, wgt_read, bias_read, acc_clr, comp_en, wr_en, busy, done, err
    );

    modport slave (
        input  start, mode, taps, windows, wr_ready,
        output ifm_read, wgt_read, bias_read, acc_clr, comp_en, wr_en, busy, done, err
    );
endinterface

// File: rtl/layer_controller.sv
// Read/compute/write sequencer for one CNN layer command; all outputs registered.
// Optional CTRL_SUSPEND_EN adds a suspend port and a SUSPEND freeze state.
//
// state   | meaning
// IDLE    | waiting for start; illegal commands pulse err
// READ    | one read beat per cycle, tap_cnt 0..taps-1
// COMP    | compute for COMP_LAT cycles (down-counter lat_cnt)
// WRITE   | wr_en held until wr_ready
// FINISH  | one-cycle done pulse
// SUSPEND | frozen; resumes resume_q at held counts (CTRL_SUSPEND_EN only)
module layer_controller #(
    parameter int CNT_W    = 4,
    parameter int WIN_W    = 10,
    parameter int COMP_LAT = 3
) (
    input logic clk,
    input logic rst_n,
`ifdef CTRL_SUSPEND_EN
    input logic suspend,
`endif
    layer_controller_if.slave bus
);
    localparam int LAT_W = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;
    localparam logic [1:0] MODE_CONV  = 2'b00;
    localparam logic [1:0] MODE_FULLY = 2'b10;
    localparam logic [1:0] MODE_BAD   = 2'b11;

    typedef enum logic [2:0] {
        IDLE, READ, COMP, WRITE, FINISH
`ifdef CTRL_SUSPEND_EN
        , SUSPEND
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [CNT_W-1:0] taps_q, taps_nxt, tap_cnt, tap_nxt;
    logic [WIN_W-1:0] windows_q, windows_nxt, win_cnt, win_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_nxt;
    logic             cmd_bad, beat0;
    logic             ifm_nxt, wgt_nxt, bias_nxt, acc_nxt, comp_nxt, wr_nxt;
    logic             busy_nxt, done_nxt, err_nxt;
`ifdef CTRL_SUSPEND_EN
    state_t           resume_q, resume_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        taps_nxt    = taps_q;
        windows_nxt = windows_q;
        tap_nxt     = tap_cnt;
        win_nxt     = win_cnt;
        lat_nxt     = lat_cnt;
        err_nxt     = 1'b0;
`ifdef CTRL_SUSPEND_EN
        resume_nxt  = resume_q;
`endif
        cmd_bad = (bus.mode == MODE_BAD) || (bus.taps == '0) || (bus.windows == '0);

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (cmd_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        mode_nxt    = bus.mode;
                        taps_nxt    = bus.taps;
                        windows_nxt = bus.windows;
                        tap_nxt     = '0;
                        win_nxt     = '0;
                        state_nxt   = READ;
                    end
                end
            end
            READ: begin
                if (tap_cnt == taps_q - CNT_W'(1)) begin
                    lat_nxt   = LAT_W'(COMP_LAT - 1);
                    state_nxt = COMP;
                end else begin
                    tap_nxt = tap_cnt + CNT_W'(1);
                end
            end
            COMP: begin
                if (lat_cnt == '0) state_nxt = WRITE;
                else               lat_nxt   = lat_cnt - LAT_W'(1);
            end
            WRITE: begin
                if (bus.wr_ready) begin
                    if (win_cnt == windows_q - WIN_W'(1)) begin
                        state_nxt = FINISH;
                    end else begin
                        win_nxt   = win_cnt + WIN_W'(1);
                        tap_nxt   = '0;
                        state_nxt = READ;
                    end
                end
            end
            FINISH: state_nxt = IDLE;
`ifdef CTRL_SUSPEND_EN
            SUSPEND: if (!suspend) state_nxt = resume_q;
`endif
            default: state_nxt = IDLE;
        endcase

`ifdef CTRL_SUSPEND_EN
        // Counters have already advanced past the beat issued this cycle, so
        // resuming at the held values neither drops nor repeats a beat.
        if (suspend && (state == READ || state == COMP)) begin
            resume_nxt = state_nxt;
            state_nxt  = SUSPEND;
        end
`endif

        beat0    = (tap_nxt == '0);
        ifm_nxt  = (state_nxt == READ);
        wgt_nxt  = ifm_nxt && ((mode_nxt == MODE_CONV && beat0) || mode_nxt == MODE_FULLY);
        bias_nxt = ifm_nxt && (mode_nxt == MODE_CONV) && beat0;
        acc_nxt  = ifm_nxt && beat0 && (mode_nxt != MODE_FULLY || win_nxt == '0);
        comp_nxt = (state_nxt == COMP);
        wr_nxt   = (state_nxt == WRITE);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= '0;
            taps_q        <= '0;
            windows_q     <= '0;
            tap_cnt       <= '0;
            win_cnt       <= '0;
            lat_cnt       <= '0;
            bus.ifm_read  <= 1'b0;
            bus.wgt_read  <= 1'b0;
            bus.bias_read <= 1'b0;
            bus.acc_clr   <= 1'b0;
            bus.comp_en   <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            mode_q        <= mode_nxt;
            taps_q        <= taps_nxt;
            windows_q     <= windows_nxt;
            tap_cnt       <= tap_nxt;
            win_cnt       <= win_nxt;
            lat_cnt       <= lat_nxt;
            bus.ifm_read  <= ifm_nxt;
            bus.wgt_read  <= wgt_nxt;
            bus.bias_read <= bias_nxt;
            bus.acc_clr   <= acc_nxt;
            bus.comp_en   <= comp_nxt;
            bus.wr_en     <= wr_nxt;
            bus.busy      <= busy_nxt;
            bus.done      <= done_nxt;
            bus.err       <= err_nxt;
        end
    end

`ifdef CTRL_SUSPEND_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resume_q <= IDLE;
        else        resume_q <= resume_nxt;
    end
`endif
endmodule

// File: doc/layer_controller.md
# layer_controller

Parametrised read/compute/write sequencer for the CNN accelerator datapath. It accepts a layer command (mode, taps per window, window count) and drives the IFM/weight/bias read enables, accumulator clear, compute enable and write-back request for the PE/pooling arrays. It then reports completion. It is the generalised successor of the fixed 9-tap controller, adding configurable tap/window counts, a start/done handshake, compute latency and write-back backpressure.

## Interface
- CNT_W, 4: width of tap counter; max taps = 2^CNT_W-1
- WIN_W, 10: width of window counter
- COMP_LAT, 3: cycles spent in COMP per window (>=1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  2  00 CONV, 01 POOL, 10 FULLY, 11 illegal
- taps  in  CNT_W  read beats per window, legal 1..max
- windows  in  WIN_W  output windows per layer, legal >=1
- wr_ready  in  1  write-back sink accepts
- ifm_read  out  1  IFM read enable
- wgt_read  out  1  weight read enable
- bias_read  out  1  bias read enable
- acc_clr  out  1  clear PE accumulators
- comp_en  out  1  compute phase active
- wr_en  out  1  write-back request
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-command pulse
- suspend  in  1  freeze request (only with CTRL_SUSPEND_EN)

Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- States: IDLE, READ, COMP, WRITE, FINISH (plus SUSPEND with macro).
- IDLE + start:
  - If mode==11, taps==0 or windows==0: err=1 for one cycle, stay IDLE.
  - Otherwise latch mode/taps/windows, clear tap_cnt and win_cnt, go READ.
- READ: tap_cnt runs 0..taps-1, one beat per cycle; ifm_read=1 every beat.
  - CONV: wgt_read=1, bias_read=1 and acc_clr=1 on beat 0 only.
  - POOL: wgt_read=bias_read=0; acc_clr=1 on beat 0.
  - FULLY: wgt_read=1 every beat; bias_read=0; acc_clr=1 on beat 0 of window 0 only (accumulates across windows).
  - After beat taps-1, go COMP.
- COMP: comp_en=1 for exactly COMP_LAT cycles, then go WRITE.
- WRITE: wr_en=1 until a cycle with wr_en&&wr_ready.
  - On that handshake: if win_cnt==windows-1, go FINISH; else win_cnt++, tap_cnt=0, go READ.
- FINISH: done=1 for one cycle, then IDLE.
- start while busy is ignored; the latched command is unaffected by input changes.
- Counters are unsigned, sized by CNT_W/WIN_W; no wrap occurs because terminal compares stop them.

## Timing
- All outputs are registered; reset value 0 for every output, state=IDLE, counters=0.
- Start accepted at edge t: busy and first ifm_read high from t+1.
- Per-window cycles = taps + COMP_LAT + 1 + wr_ready stall cycles.
- wr_en is held stable until accepted; wr_ready outside WRITE has no effect.
- done is asserted in the cycle after the final write handshake; busy falls with done.
- rst_n low at any time (mid-READ/COMP/WRITE) returns immediately to reset values; no done pulse.

## Configuration
- CTRL_SUSPEND_EN defined: `suspend` port exists.
  - suspend=1 in READ or COMP enters SUSPEND on the next edge: all read enables, acc_clr and comp_en are 0, counters hold, busy stays 1.
  - suspend=0 resumes the saved state at the held count; no beat is lost or repeated.
  - suspend is ignored in IDLE, WRITE and FINISH.
- Not defined: no `suspend` port, no SUSPEND state; sequencing is never paused except by wr_ready.

## Test plan
- CONV, taps=9, windows=2, wr_ready=1: per window ifm_read high 9 cycles, wgt/bias/acc_clr high only on beat 0, comp_en 3 cycles, wr_en 1 cycle; done at cycle 27 after start.
- POOL, taps=4, windows=1: wgt_read/bias_read never high; 4 ifm beats; done pulse then busy=0.
- FULLY, taps=3, windows=3: wgt_read high on all 9 beats; acc_clr high exactly once.
- Illegal commands (mode=11; taps=0; windows=0): err pulse only, busy stays 0, no read enables.
- wr_ready held low 5 cycles in WRITE: wr_en stays high 6 cycles; no extra window counted; rst_n pulsed mid-COMP returns all outputs to 0.
- With CTRL_SUSPEND_EN: suspend 2 cycles at READ beat 4 of 9: enables drop, then resume at beat 5; total ifm beats = 9.
